alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Multi-cycle RV32M multiply/divide unit for the execute stage; sits alongside the combinational ALU.
//  - Accepts one op per valid/ready handshake.
//  - Iterates over DWIDTH cycles, then holds the result until the downstream stage consumes it.
//  - Carries a destination tag so writeback can match results; supports pipeline flush.
// PARAMETERS
//  DWIDTH  32  operand/result width (even, >=8)
//  TAG_W   5   width of pass-through destination tag (rd index)
// PORTS
//  clk       in   1       clock, all state on rising edge
//  reset     in   1       asynchronous, active-high reset
//  valid_i   in   1       request valid
//  ready_o   out  1       unit can accept (IDLE only)
//  funct3_i  in   3       RV32M op: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1_i     in   DWIDTH  operand A (dividend / multiplicand)
//  rs2_i     in   DWIDTH  operand B (divisor / multiplier)
//  tag_i     in   TAG_W   destination tag, returned unchanged on tag_o
//  flush_i   in   1       abort in-flight/held op
//  valid_o   out  1       result valid
//  ready_i   in   1       downstream accepts result
//  res_o     out  DWIDTH  result
//  tag_o     out  TAG_W   tag of result
//  busy_o    out  1       state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; ready_o=1, valid_o=0, busy_o=0, res_o=0, tag_o=0, counter=0.
//  FSM: IDLE -> MUL | DIV | DONE; MUL -> DONE; DIV -> DONE; DONE -> IDLE.
//   - IDLE: accept on valid_i&&ready_o. Latch operands, op, tag; record operand signs;
//     convert signed operands to magnitudes (MULH: both; MULHSU: rs1 only; DIV/REM: both).
//   - MUL: shift-add on 2*DWIDTH-bit product, one bit per cycle, exactly DWIDTH cycles.
//   - DIV: restoring radix-2, one quotient bit per cycle, exactly DWIDTH cycles.
//   - Counter runs DWIDTH-1..0; leave on 0.
//   - DONE: valid_o=1, res_o/tag_o stable; leave on ready_i (result consumed that cycle).
//  Latency, accept edge to valid_o: DWIDTH+1 cycles for normal ops. Throughput: 1 op per DWIDTH+2 cycles min.
//  Sign fix-up applied on entering DONE:
//   - product negated (2*DWIDTH wide) if sign differs;
//   - quotient negated if signs differ; remainder takes dividend sign.
//  Result select:
//   - MUL = product low DWIDTH bits; MULH/MULHSU/MULHU = product high DWIDTH bits.
//  Special cases (IDLE -> DONE directly, latency 1):
//   - divisor 0: DIV/DIVU = all ones, REM/REMU = rs1.
//   - signed overflow (rs1 = most-negative, rs2 = -1): DIV = most-negative, REM = 0.
//  flush_i:
//   - any state -> IDLE next edge; valid_o=0 next cycle; result discarded.
//   - flush overrides a same-cycle accept (request dropped) and a same-cycle ready_i.
//  Inputs are ignored when ready_o=0; no back-to-back accept from DONE (must pass IDLE).
// CONFIGURATION
//  ALU_MULDIV_FAST_MUL_EN defined:
//   - MUL* ops use a single-cycle combinational 2*DWIDTH multiply.
//   - IDLE -> DONE directly, latency 1; MUL state unused.
//  Not defined: iterative multiplier as above. Divide path is identical in both builds.
// STRUCTURE
//  Package alu_muldiv_pkg:
//   - muldiv_op_e: funct3 encodings.
//   - muldiv_state_e: IDLE, MUL, DIV, DONE.
//   - helpers is_div(), is_signed_a(), is_signed_b().
//  Sub-module divu_iter: unsigned restoring divider datapath (start, step, quotient, remainder).
//   - Instantiated once; FSM and sign logic stay in alu_muldiv.
// TESTING
//  1. MUL 7 * -3, tag 5 -> after 33 cycles valid_o=1, res_o=0xFFFFFFEB, tag_o=5.
//  2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//     MULHSU -1*2 -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIV x/0 -> 0xFFFFFFFF and REM 9/0 -> 9 in 1 cycle; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  5. Backpressure: hold ready_i=0 10 cycles in DONE -> res_o/tag_o stable, ready_o=0.
//     Then ready_i=1 -> IDLE next cycle.
//  6. flush_i at cycle 10 of DIV -> IDLE next edge, valid_o never 1.
//     Assert reset mid-MUL -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide unit.
package alu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // MUL is treated as signed; its low half is identical either way.
    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/alu_muldiv_divu.sv
// Unsigned restoring radix-2 divider datapath: one quotient bit per step.
// The *_nxt outputs show the values after the current step completes.
module divu_iter #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic [DWIDTH-1:0] dividend,
    input  logic [DWIDTH-1:0] divisor,
    output logic [DWIDTH-1:0] quotient_nxt,
    output logic [DWIDTH-1:0] remainder_nxt
);

    logic [DWIDTH-1:0] rem_q;
    logic [DWIDTH-1:0] quo_q;
    logic [DWIDTH-1:0] dvs_q;
    logic [DWIDTH:0]   shifted;
    logic [DWIDTH:0]   trial;

    // A borrow out of the top bit means the trial subtraction must be undone.
    always_comb begin
        shifted       = {rem_q, quo_q[DWIDTH-1]};
        trial         = shifted - {1'b0, dvs_q};
        remainder_nxt = trial[DWIDTH] ? shifted[DWIDTH-1:0] : trial[DWIDTH-1:0];
        quotient_nxt  = {quo_q[DWIDTH-2:0], ~trial[DWIDTH]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= remainder_nxt;
            quo_q <= quotient_nxt;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M multiply/divide unit with tag pass-through and flush.
// Define ALU_MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [DWIDTH-1:0] rs1_i,
    input  logic [DWIDTH-1:0] rs2_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DWIDTH-1:0] res_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              busy_o,
    output muldiv_state_e     dbg_state_o
);

    // Handshake: a request transfers on a rising edge where valid_i && ready_o
    // (IDLE only) and flush_i is low; a result transfers where valid_o && ready_i.
    localparam int CNT_W = $clog2(DWIDTH);
    localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    muldiv_state_e       state_q, state_d;
    muldiv_op_e          op_in, op_q;
    logic                neg_a_in, neg_b_in, neg_a_q, neg_b_q;
    logic [DWIDTH-1:0]   a_mag_in, b_mag_in, a_mag_q;
    logic [2*DWIDTH-1:0] prod_q, prod_nxt;
    logic [DWIDTH:0]     mul_sum;
    logic [CNT_W-1:0]    cnt_q;
    logic [DWIDTH-1:0]   res_q;
    logic [TAG_W-1:0]    tag_q;
    logic                div_zero, div_ovf, special, accept;
    logic [DWIDTH-1:0]   special_res;
    logic [DWIDTH-1:0]   quo_nxt, rem_nxt;

    function automatic logic [DWIDTH-1:0] mul_select(input muldiv_op_e op,
                                                     input logic [2*DWIDTH-1:0] prod,
                                                     input logic neg);
        logic [2*DWIDTH-1:0] p;
        p = neg ? -prod : prod;
        return (op == OP_MUL) ? p[DWIDTH-1:0] : p[2*DWIDTH-1:DWIDTH];
    endfunction

    function automatic logic [DWIDTH-1:0] div_select(input muldiv_op_e op,
                                                     input logic [DWIDTH-1:0] q,
                                                     input logic [DWIDTH-1:0] r,
                                                     input logic neg_a,
                                                     input logic neg_b);
        if (op inside {OP_REM, OP_REMU})
            return neg_a ? -r : r;
        return (neg_a ^ neg_b) ? -q : q;
    endfunction

    always_comb begin
        op_in    = muldiv_op_e'(funct3_i);
        neg_a_in = is_signed_a(op_in) && rs1_i[DWIDTH-1];
        neg_b_in = is_signed_b(op_in) && rs2_i[DWIDTH-1];
        a_mag_in = neg_a_in ? -rs1_i : rs1_i;
        b_mag_in = neg_b_in ? -rs2_i : rs2_i;
        div_zero = (rs2_i == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (rs1_i == MOST_NEG) && (rs2_i == '1);
        special  = is_div(op_in) && (div_zero || div_ovf);
        if (div_zero)
            special_res = (op_in inside {OP_REM, OP_REMU}) ? rs1_i : '1;
        else
            special_res = (op_in == OP_REM) ? '0 : MOST_NEG;
        accept   = valid_i && (state_q == S_IDLE) && !flush_i;
    end

    // Shift-add: add multiplicand into the upper half when the multiplier LSB is set.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*DWIDTH-1:DWIDTH]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
        prod_nxt = {mul_sum, prod_q[DWIDTH-1:1]};
    end

    divu_iter #(.DWIDTH(DWIDTH)) u_divu (
        .clk          (clk),
        .reset        (reset),
        .start        (accept && is_div(op_in)),
        .step         ((state_q == S_DIV) && !flush_i),
        .dividend     (a_mag_in),
        .divisor      (b_mag_in),
        .quotient_nxt (quo_nxt),
        .remainder_nxt(rem_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (valid_i) begin
                    if (is_div(op_in))
                        state_d = special ? S_DONE : S_DIV;
                    else
`ifdef ALU_MULDIV_FAST_MUL_EN
                        state_d = S_DONE;
`else
                        state_d = S_MUL;
`endif
                end
                S_MUL, S_DIV: if (cnt_q == '0) state_d = S_DONE;
                S_DONE: if (ready_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o     = (state_q == S_IDLE);
        valid_o     = (state_q == S_DONE);
        busy_o      = (state_q != S_IDLE);
        res_o       = res_q;
        tag_o       = tag_q;
        dbg_state_o = state_q;
    end

    // Sign fix-up is folded into the last iteration so DONE holds the final result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= OP_MUL;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            a_mag_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
        end else if (!flush_i) begin
            case (state_q)
                S_IDLE: if (valid_i) begin
                    op_q    <= op_in;
                    tag_q   <= tag_i;
                    neg_a_q <= neg_a_in;
                    neg_b_q <= neg_b_in;
                    a_mag_q <= a_mag_in;
                    prod_q  <= {{DWIDTH{1'b0}}, b_mag_in};
                    cnt_q   <= CNT_W'(DWIDTH - 1);
                    if (special)
                        res_q <= special_res;
`ifdef ALU_MULDIV_FAST_MUL_EN
                    else if (!is_div(op_in))
                        res_q <= mul_select(op_in,
                                            {{DWIDTH{1'b0}}, a_mag_in} * {{DWIDTH{1'b0}}, b_mag_in},
                                            neg_a_in ^ neg_b_in);
`endif
                end
                S_MUL: begin
                    prod_q <= prod_nxt;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0)
                        res_q <= mul_select(op_q, prod_nxt, neg_a_q ^ neg_b_q);
                end
                S_DIV: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0)
                        res_q <= div_select(op_q, quo_nxt, rem_nxt, neg_a_q, neg_b_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (default iterative build).
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_i, ready_o, flush_i, valid_o, ready_i, busy_o;
    logic [2:0]    funct3_i;
    logic [W-1:0]  rs1_i, rs2_i, res_o;
    logic [TW-1:0] tag_i, tag_o;
    muldiv_state_e dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.DWIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .funct3_i   (funct3_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .tag_i      (tag_i),
        .flush_i    (flush_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .res_o      (res_o),
        .tag_o      (tag_o),
        .busy_o     (busy_o),
        .dbg_state_o(dbg_state_o)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] t);
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        tag_i    = t;
        valid_i  = 1'b1;
        tick();
        valid_i  = 1'b0;
    endtask

    // Counts edges from driving valid_i until valid_o is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (valid_o !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] t,
                          input logic [W-1:0] exp_res, input int exp_lat);
        int lat;
        issue(f3, a, b, t);
        wait_valid(lat);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_res"}, res_o, exp_res);
        check({name, "_tag"}, tag_o, t);
        tick();
        check({name, "_idle"}, {valid_o, ready_o}, 2'b01);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic seen_valid;
        reset    = 1'b0;
        valid_i  = 1'b0;
        flush_i  = 1'b0;
        ready_i  = 1'b1;
        funct3_i = 3'b000;
        rs1_i    = '0;
        rs2_i    = '0;
        tag_i    = '0;
        #1 reset = 1'b1;
        #2;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_res", res_o, 0);
        check("rst_tag", tag_o, 0);
        check("rst_state", dbg_state_o, S_IDLE);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Multiplies
        run_op("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
        run_op("mul_lo",  3'b000, 32'h12345678, 32'h00000010, 5'd6,  32'h23456780, 33);
        run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 33);
        run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33);
        run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 33);

        // Divides
        run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33);
        run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
        run_op("divu",    3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       33);
        run_op("remu",    3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        33);
        run_op("div_pn",  3'b100, 32'd7,        32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, 33);
        run_op("rem_pn",  3'b110, 32'd7,        32'hFFFFFFFE, 5'd12, 32'd1,        33);
        run_op("divu_mx", 3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        33);

        // Special cases complete in one cycle
        run_op("div_z",   3'b100, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
        run_op("divu_z",  3'b101, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1);
        run_op("rem_z",   3'b110, 32'd9,        32'd0,        5'd16, 32'd9,        1);
        run_op("remu_z",  3'b111, 32'd9,        32'd0,        5'd17, 32'd9,        1);
        run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1);
        run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1);

        // Backpressure in DONE
        ready_i = 1'b0;
        issue(3'b101, 32'd100, 32'd7, 5'd9);
        wait_valid(lat);
        check("bp_lat", lat, 33);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_res", res_o, 32'd14);
            check("bp_tag", tag_o, 5'd9);
            check("bp_hold", {valid_o, ready_o}, 2'b10);
        end
        ready_i = 1'b1;
        tick();
        check("bp_release", {valid_o, ready_o, busy_o}, 3'b010);

        // Flush on cycle 10 of a divide
        issue(3'b100, 32'd1000, 32'd3, 5'd4);
        check("fl_state", dbg_state_o, S_DIV);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("fl_novalid", valid_o, 0);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fl_idle", {ready_o, busy_o}, 2'b10);
        check("fl_state_idle", dbg_state_o, S_IDLE);
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_o === 1'b1) seen_valid = 1'b1;
        end
        check("fl_never_valid", seen_valid, 0);

        // Flush drops a same-cycle request
        funct3_i = 3'b000;
        rs1_i    = 32'd3;
        rs2_i    = 32'd4;
        valid_i  = 1'b1;
        flush_i  = 1'b1;
        tick();
        valid_i  = 1'b0;
        flush_i  = 1'b0;
        check("fl_drop", {ready_o, busy_o}, 2'b10);

        // Flush discards a held result
        ready_i = 1'b0;
        issue(3'b101, 32'd50, 32'd0, 5'd21);
        check("fl_done_valid", valid_o, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        ready_i = 1'b1;
        check("fl_done_drop", {valid_o, ready_o}, 2'b01);

        run_op("post_fl", 3'b000, 32'd6, 32'd7, 5'd22, 32'd42, 33);

        // Asynchronous reset mid-multiply
        issue(3'b000, 32'd5, 32'd6, 5'd3);
        for (int i = 0; i < 5; i++) tick();
        check("ar_busy", busy_o, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_ready", ready_o, 1);
        check("ar_valid", valid_o, 0);
        check("ar_busy0", busy_o, 0);
        check("ar_res", res_o, 0);
        check("ar_tag", tag_o, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        run_op("post_rst", 3'b101, 32'd100, 32'd7, 5'd23, 32'd14, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
